// File: rtl/reset_request_gen.sv
// reset_request_gen: synchronizes and debounces the reset button, classifies presses, merges keyboard requests
module reset_request_gen #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_CYCLES       = 100000000,
    parameter int HOST_PULSE_CYCLES = 64
) (
    input  logic clk50,
    input  logic reset,
    input  logic btn_n,
    input  logic kbd_reset_req,
    output logic key_reset,
    output logic host_reset_n,
    output logic btn_pressed,
    output logic long_armed
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam int PW = $clog2(HOST_PULSE_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(HOST_PULSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, HOST_PULSE, WAIT_RELEASE} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_deb_cnt;
    logic                   r_btn_pressed;
    state_t                 r_state, w_state_nx;
    logic [HW-1:0]          r_hold_cnt, w_hold_nx;
    logic [PW-1:0]          r_pulse_cnt, w_pulse_nx;
    logic                   r_key_reset, w_key_nx;
    logic                   r_host_reset_n, w_host_nx;
    logic                   r_long_armed, w_armed_nx;
    logic                   w_sync_pressed, w_toggle, w_rise, w_fall;

    assign w_sync_pressed = ~r_sync[SYNC_STAGES-1];
    // The FSM reacts to the debounced edge in the same cycle the level register flips.
    assign w_toggle = (w_sync_pressed != r_btn_pressed) && (r_deb_cnt == DEB_LAST);
    assign w_rise   = w_toggle && !r_btn_pressed;
    assign w_fall   = w_toggle && r_btn_pressed;

    // Bring the asynchronous button into the clk50 domain; released level is 1.
    always_ff @(posedge clk50) begin
        if (reset) r_sync <= '1;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], btn_n};
    end

    // Accept a level change only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_btn_pressed <= 1'b0;
            r_deb_cnt     <= '0;
        end else if (w_sync_pressed == r_btn_pressed) begin
            r_deb_cnt     <= '0;
        end else if (w_toggle) begin
            r_btn_pressed <= ~r_btn_pressed;
            r_deb_cnt     <= '0;
        end else begin
            r_deb_cnt     <= r_deb_cnt + DW'(1);
        end
    end

    // State, counters and registered outputs of the press classifier.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state        <= IDLE;
            r_hold_cnt     <= '0;
            r_pulse_cnt    <= '0;
            r_key_reset    <= 1'b0;
            r_host_reset_n <= 1'b1;
            r_long_armed   <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_hold_cnt     <= w_hold_nx;
            r_pulse_cnt    <= w_pulse_nx;
            r_key_reset    <= w_key_nx;
            r_host_reset_n <= w_host_nx;
            r_long_armed   <= w_armed_nx;
        end
    end

    // Next-state logic; keyboard requests are blocked right after a key pulse so it never lasts two cycles.
    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold_cnt;
        w_pulse_nx = r_pulse_cnt;
        w_key_nx   = 1'b0;
        w_host_nx  = 1'b1;
        w_armed_nx = r_long_armed;
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nx = PRESSED;
                    w_hold_nx  = '0;
                    w_armed_nx = 1'b1;
                end else if (kbd_reset_req && !r_key_reset) begin
                    w_key_nx   = 1'b1;
                end
            end
            PRESSED: begin
                w_hold_nx = r_hold_cnt + HW'(1);
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nx = HOST_PULSE;
                    w_host_nx  = 1'b0;
                    w_pulse_nx = '0;
                end else if (w_fall) begin
                    w_state_nx = IDLE;
                    w_key_nx   = 1'b1;
                    w_armed_nx = 1'b0;
                end
            end
            HOST_PULSE: begin
                w_pulse_nx = r_pulse_cnt + PW'(1);
                w_host_nx  = r_pulse_cnt == PULSE_LAST;
                w_state_nx = r_pulse_cnt == PULSE_LAST ? WAIT_RELEASE : HOST_PULSE;
            end
            WAIT_RELEASE: begin
                if (!r_btn_pressed) begin
                    w_state_nx = IDLE;
                    w_armed_nx = 1'b0;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign key_reset    = r_key_reset;
    assign host_reset_n = r_host_reset_n;
    assign btn_pressed  = r_btn_pressed;
    assign long_armed   = r_long_armed;
endmodule

// File: tb/tb_reset_request_gen.sv
// tb_reset_request_gen: directed and random stimulus against a timestamp-based press model
module tb_reset_request_gen;
    localparam int S = 2;
    localparam int D = 4;
    localparam int L = 20;
    localparam int H = 3;

    logic clk50 = 1'b0;
    logic reset = 1'b1;
    logic btn_n = 1'b1;
    logic kbd_reset_req = 1'b0;
    logic key_reset, host_reset_n, btn_pressed, long_armed;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int key_cnt = 0;
    int low_cnt = 0;
    int bp_cnt = 0;
    logic last_key = 1'b0;

    bit m_hist[S];
    bit m_deb = 0;
    bit m_key = 0;
    bit m_armed = 0;
    bit m_host = 1;
    int m_run = 0;
    int m_t0 = -1;

    reset_request_gen #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .HOST_PULSE_CYCLES(H)
    ) dut (
        .clk50(clk50), .reset(reset), .btn_n(btn_n), .kbd_reset_req(kbd_reset_req),
        .key_reset(key_reset), .host_reset_n(host_reset_n),
        .btn_pressed(btn_pressed), .long_armed(long_armed)
    );

    always #5 clk50 = ~clk50;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // A press is a timestamp m_t0; its age decides short/long/pulse/release behaviour.
    function automatic void model_edge();
        bit sp, prev_deb, prev_key, rise, fall;
        int age;
        if (reset) begin
            foreach (m_hist[i]) m_hist[i] = 1;
            m_deb = 0; m_run = 0; m_t0 = -1; m_key = 0; m_armed = 0; m_host = 1;
            n++;
            return;
        end
        sp = !m_hist[S-1];
        prev_deb = m_deb;
        prev_key = m_key;
        rise = 0;
        fall = 0;
        if (sp != m_deb) begin
            m_run++;
            if (m_run == D) begin
                rise = sp;
                fall = !sp;
                m_deb = sp;
                m_run = 0;
            end
        end else m_run = 0;
        m_key = 0;
        if (m_t0 < 0) begin
            if (rise) begin
                m_t0 = n;
                m_armed = 1;
            end else if (kbd_reset_req && !prev_key) m_key = 1;
        end else begin
            age = n - m_t0;
            if (age < L && fall) begin
                m_t0 = -1; m_armed = 0; m_key = 1;
            end else if (age > L + H && !prev_deb) begin
                m_t0 = -1; m_armed = 0;
            end
        end
        m_host = !(m_t0 >= 0 && n - m_t0 >= L && n - m_t0 < L + H);
        for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = btn_n;
        n++;
    endfunction

    task automatic step();
        @(posedge clk50);
        model_edge();
        #1;
        check("key_reset", key_reset, m_key);
        check("host_reset_n", host_reset_n, m_host);
        check("btn_pressed", btn_pressed, m_deb);
        check("long_armed", long_armed, m_armed);
        check("key_twice", int'(key_reset && last_key), 0);
        check("key_with_host", int'(key_reset && !host_reset_n), 0);
        key_cnt += int'(key_reset);
        low_cnt += int'(!host_reset_n);
        bp_cnt += int'(btn_pressed);
        last_key = key_reset;
    endtask

    initial begin
        int lat, t_bp, t_host, runlen;
        repeat (3) step();
        check("rst_key", key_reset, 0);
        check("rst_host", host_reset_n, 1);
        check("rst_bp", btn_pressed, 0);
        check("rst_armed", long_armed, 0);
        reset = 1'b0;
        key_cnt = 0; low_cnt = 0; bp_cnt = 0;
        repeat (50) step();
        check("idle_keys", key_cnt, 0);
        check("idle_host", low_cnt, 0);
        check("idle_bp", bp_cnt, 0);

        key_cnt = 0; bp_cnt = 0;
        btn_n = 0; repeat (3) step();
        btn_n = 1; step();
        btn_n = 0; repeat (3) step();
        btn_n = 1; repeat (20) step();
        check("bounce_bp", bp_cnt, 0);
        check("bounce_key", key_cnt, 0);

        key_cnt = 0; low_cnt = 0; lat = -1;
        btn_n = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (btn_pressed && lat < 0) lat = i;
        end
        check("short_lat", lat, 6);
        check("short_armed", long_armed, 1);
        btn_n = 1; repeat (30) step();
        check("short_keys", key_cnt, 1);
        check("short_host", low_cnt, 0);
        check("short_armed_clr", long_armed, 0);

        key_cnt = 0; low_cnt = 0; t_bp = -1; t_host = -1;
        btn_n = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (btn_pressed && t_bp < 0) t_bp = i;
            if (!host_reset_n && t_host < 0) t_host = i;
        end
        check("long_bp_seen", int'(t_bp > 0), 1);
        check("long_delay", t_host - t_bp, L);
        check("long_width", low_cnt, H);
        check("long_armed_hold", long_armed, 1);
        btn_n = 1; repeat (20) step();
        check("long_armed_clr", long_armed, 0);
        check("long_keys", key_cnt, 0);

        kbd_reset_req = 1; step();
        check("kbd_pulse", key_reset, 1);
        kbd_reset_req = 0; step();
        check("kbd_single", key_reset, 0);
        key_cnt = 0;
        btn_n = 0; repeat (10) step();
        kbd_reset_req = 1; step();
        kbd_reset_req = 0;
        check("kbd_pressed", key_cnt, 0);
        btn_n = 1; repeat (30) step();
        check("kbd_short_after", key_cnt, 1);

        btn_n = 0; t_host = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (!host_reset_n) begin
                t_host = i;
                break;
            end
        end
        check("rst_host_seen", int'(t_host > 0), 1);
        step();
        check("rst_host_low2", host_reset_n, 0);
        reset = 1; step();
        check("rst_host_rel", host_reset_n, 1);
        check("rst_abort_armed", long_armed, 0);
        check("rst_abort_bp", btn_pressed, 0);
        reset = 0; lat = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (btn_pressed && lat < 0) lat = i;
        end
        check("rst_relat", lat, 6);
        btn_n = 1; repeat (40) step();

        runlen = 0;
        for (int c = 0; c < 4000; c++) begin
            if (runlen == 0) begin
                btn_n = ~btn_n;
                runlen = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 45 : 6);
            end
            runlen--;
            kbd_reset_req = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 0; kbd_reset_req = 0; btn_n = 1;
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
